// File: rtl/muldiv_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
package muldiv_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_CALC = 2'd1;
  localparam logic [1:0] MD_FIX  = 2'd2;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring divide.
// The accumulator holds {upper : lower}; for divide that is {remainder : quotient}.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   partial;
  logic [WIDTH-1:0] trial;

  always_comb begin
    add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand} : '0);
    partial = acc_i[2*WIDTH-1:WIDTH-1];
    // Only used when partial >= operand, where the difference always fits in WIDTH bits.
    trial   = partial[WIDTH-1:0] - operand;
    acc_o   = {add_sum, acc_i[WIDTH-1:1]};
    if (is_div) begin
      if (partial >= {1'b0, operand}) begin
        acc_o = {trial, acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {partial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/muldiv.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Operands are processed as magnitudes; signs are reapplied in the FIX cycle.
module muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] busA,
  input  logic [WIDTH-1:0] busB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div_zero_q, div_zero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               signed_op, start_div, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, quot, rem;
  logic [2*WIDTH-1:0] step_acc, prod;

  assign signed_op = (op == MD_MULT) || (op == MD_DIV);
  assign start_div = (op == MD_DIV) || (op == MD_DIVU);
  assign a_neg     = signed_op & busA[WIDTH-1];
  assign b_neg     = signed_op & busB[WIDTH-1];
  assign a_mag     = a_neg ? -busA : busA;
  assign b_mag     = b_neg ? -busB : busB;

  assign quot = acc_q[WIDTH-1:0];
  assign rem  = acc_q[2*WIDTH-1:WIDTH];
  assign prod = neg_res_q ? -acc_q : acc_q;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i   (acc_q),
    .operand (opnd_q),
    .is_div  (is_div_q),
    .acc_o   (step_acc)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    is_div_d   = is_div_q;
    neg_res_d  = neg_res_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              is_div_d   = start_div;
              // Divide seeds {0 : dividend}; multiply seeds {0 : multiplier}.
              acc_d      = start_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
              opnd_d     = start_div ? b_mag : a_mag;
              neg_res_d  = a_neg ^ b_neg;
              neg_rem_d  = a_neg;
              div_zero_d = (busB == '0);
              cnt_d      = '0;
              state_d    = MD_CALC;
            end
            MD_MTHI: hi_d = busA;
            MD_MTLO: lo_d = busA;
            default: ;
          endcase
        end
      end
      MD_CALC: begin
        acc_d = step_acc;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        if (is_div_q) begin
          // Divide by zero reports an all-ones quotient regardless of operand signs.
          lo_d = div_zero_q ? '1 : (neg_res_q ? -quot : quot);
          hi_d = neg_rem_q ? -rem : rem;
        end else begin
          {hi_d, lo_d} = prod;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= MD_IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opnd_q     <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      is_div_q   <= is_div_d;
      neg_res_q  <= neg_res_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
    end
  end

  assign busy = (state_q != MD_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv.sv
// Scoreboard bench for muldiv: driver pushes reference results, monitor checks on done.
module tb_muldiv;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] busA = 32'd0;
  logic [31:0] busB = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .op    (op),
    .busA  (busA),
    .busB  (busB),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;
  bit          mon_en = 1'b0;
  logic        prev_done = 1'b0;
  int          last_done_cyc = -100;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference results from plain integer arithmetic: returns {hi, lo}.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    p   = 64'd0;
    case (o)
      3'd0: p = sa * sbv;
      3'd1: p = {32'd0, a} * {32'd0, b};
      3'd2: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end
      end
      3'd3: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Monitor: all DUT outputs sampled on the falling edge.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      logic exp_busy;
      exp_busy = (sb.size() != 0) && (done !== 1'b1);
      check("busy", 64'(busy), 64'(exp_busy));
      if (prev_done === 1'b1) check("done_one_cycle", 64'(done), 64'd0);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("done_without_op", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("result_hi", 64'(hi), 64'(e.hi));
          check("result_lo", 64'(lo), 64'(e.lo));
          check("latency", 64'(cyc - e.acc_cyc), 64'd33);
          if (e.acc_cyc == last_done_cyc + 1) check("b2b_gap", 64'(cyc - last_done_cyc), 64'd34);
          model_hi = e.hi;
          model_lo = e.lo;
        end
        last_done_cyc = cyc;
      end else begin
        check("hi_hold", 64'(hi), 64'(model_hi));
        check("lo_hold", 64'(lo), 64'(model_lo));
      end
      prev_done = done;
    end
  end

  // Called at posedge+1: waits for idle, presents the request, records expectations.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    exp_t e;
    logic [63:0] r;
    n = 0;
    while (busy !== 1'b0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) begin
      check("busy_wait_timeout", 64'(busy), 64'd0);
      return;
    end
    op = o; busA = a; busB = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (o <= 3'd3) begin
      r = model(o, a, b);
      e.hi = r[63:32];
      e.lo = r[31:0];
      e.acc_cyc = cyc;
      sb.push_back(e);
    end else if (o == 3'd4) begin
      model_hi = a;
    end else if (o == 3'd5) begin
      model_lo = a;
    end
    $display("issue op=%0d a=%h b=%h cycle=%0d", o, a, b, cyc);
  endtask

  // Presents a request for one cycle without waiting; the DUT is expected to ignore it.
  task automatic force_start(input logic [2:0] o, input logic [31:0] a);
    op = o; busA = a; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    $display("forced op=%0d a=%h while busy cycle=%0d", o, a, cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    sb.delete();
    model_hi = 32'd0;
    model_lo = 32'd0;
    $display("reset applied cycle=%0d", cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ext [5];
    logic [31:0] a, b;
    logic [2:0]  o;
    int          sel;
    ext[0] = 32'h8000_0000; ext[1] = 32'hFFFF_FFFF; ext[2] = 32'd0;
    ext[3] = 32'd1;         ext[4] = 32'h7FFF_FFFF;

    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    mon_en = 1'b1;

    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    issue(3'd0, -32'sd3, 32'd7);
    issue(3'd2, -32'sd7, 32'd2);
    issue(3'd3, 32'd100, 32'd0);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    issue(3'd2, -32'sd5, 32'd0);
    drain();

    issue(3'd3, 32'd1000, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    force_start(3'd4, 32'h1234);
    force_start(3'd5, 32'h5678);
    drain();

    issue(3'd5, 32'h55, 32'd0);
    issue(3'd4, 32'hCAFE, 32'd0);
    issue(3'd6, 32'h1111, 32'h2222);
    repeat (2) @(posedge clk);
    #1;

    issue(3'd1, 32'hDEAD_BEEF, 32'h1234_5678);
    issue(3'd1, 32'h0000_FFFF, 32'h0001_0001);
    drain();

    issue(3'd3, 32'd12345, 32'd17);
    repeat (9) @(posedge clk);
    #1;
    pulse_reset();
    repeat (40) @(posedge clk);
    #1;

    for (int i = 0; i < 60; i++) begin
      o   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 3);
      case (sel)
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom; b = 32'd0; end
        2: begin a = 32'($signed($urandom_range(0, 200)) - 100); b = 32'($signed($urandom_range(0, 20)) - 10); end
        default: begin a = ext[$urandom_range(0, 4)]; b = ext[$urandom_range(0, 4)]; end
      endcase
      issue(o, a, b);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1;
      end
    end
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
